vga_sync_gen: RTL and testbench

Free-running 640x480@60 Hz raster timing generator clocked by the 25 MHz pixel clock. It produces the `pixel_x`/`pixel_y` coordinates consumed by every graphic controller (score overlay, road, cars), plus the sync, blanking and frame/line strobes used by the VGA output pins and the game logic. It sits directly upstream of all per-pixel renderers, so every downstream stage sees the same coordinate stream.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/mod_counter.sv | 20 ++
 rtl/vga_sync_gen.sv | 103 ++++++++++
 tb/tb_vga_sync_gen.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the raster generator and its counters.
package vga_timing_pkg;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL     = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL     = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HSYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_HSYNC_END   = VGA_HSYNC_START + VGA_H_SYNC;
  localparam int VGA_VSYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_VSYNC_END   = VGA_VSYNC_START + VGA_V_SYNC;

  localparam int COORD_W = 10;

  function automatic logic in_window(logic [COORD_W-1:0] pos, logic [COORD_W-1:0] lo,
                                     logic [COORD_W-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction
endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with increment enable; wrap is high on the cycle it rolls over.
module mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = inc && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// Free-running raster timing generator; outputs are a registered decode of the h/v counters.
// Optional VGA_SYNC_DELAY_EN adds one pclk of delay on video_on/hsync/vsync only.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic                pclk,
  input  logic                rst_n,
  output logic [COORD_W-1:0]  pixel_x,
  output logic [COORD_W-1:0]  pixel_y,
  output logic                video_on,
  output logic                hsync,
  output logic                vsync,
  output logic                line_tick,
  output logic                frame_tick,
  output logic [15:0]         frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] H_LAST_C = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] HS_LO    = COORD_W'(H_VISIBLE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI    = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_LO    = COORD_W'(V_VISIBLE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI    = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, v_wrap;
  logic [15:0]        frm_cnt;
  logic               vid_r, hs_r, vs_r;

  mod_counter #(.MOD(H_TOTAL), .W(COORD_W)) u_h_cnt (
    .clk(pclk), .rst_n(rst_n), .inc(1'b1), .cnt(h_cnt), .wrap(h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(COORD_W)) u_v_cnt (
    .clk(pclk), .rst_n(rst_n), .inc(h_wrap), .cnt(v_cnt), .wrap(v_wrap)
  );

  // Bumps on the same edge the counters return to (0,0), so the registered
  // copy appears together with the (0,0) output.
  always_ff @(posedge pclk) begin
    if (!rst_n)      frm_cnt <= '0;
    else if (v_wrap) frm_cnt <= frm_cnt + 16'd1;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      vid_r       <= 1'b0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      vid_r       <= (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
      hs_r        <= !in_window(h_cnt, HS_LO, HS_HI);
      vs_r        <= !in_window(v_cnt, VS_LO, VS_HI);
      line_tick   <= (h_cnt == H_LAST_C);
      frame_tick  <= (h_cnt == '0) && (v_cnt == V_VIS_C);
      frame_count <= frm_cnt;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Lines up sync/blank with rgb coming out of 1-cycle-latency bitmap ROMs.
  logic vid_d, hs_d, vs_d;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vid_d <= 1'b0;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
    end else begin
      vid_d <= vid_r;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
    end
  end

  assign video_on = vid_d;
  assign hsync    = hs_d;
  assign vsync    = vs_d;
`else
  assign video_on = vid_r;
  assign hsync    = hs_r;
  assign vsync    = vs_r;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: full-size DUT for line timing, shrunken-timing DUT for whole frames.
module tb_vga_sync_gen;
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_count;
  } out_t;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  logic [9:0]  x0, y0, x1, y1;
  logic        vo0, hs0, vs0, lt0, ft0, vo1, hs1, vs1, lt1, ft1;
  logic [15:0] fc0, fc1;

  vga_sync_gen u_full (
    .pclk(pclk), .rst_n(rst_n), .pixel_x(x0), .pixel_y(y0), .video_on(vo0),
    .hsync(hs0), .vsync(vs0), .line_tick(lt0), .frame_tick(ft0), .frame_count(fc0)
  );

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .pclk(pclk), .rst_n(rst_n), .pixel_x(x1), .pixel_y(y1), .video_on(vo1),
    .hsync(hs1), .vsync(vs1), .line_tick(lt1), .frame_tick(ft1), .frame_count(fc1)
  );

  out_t act [2];
  assign act[0] = {x0, y0, vo0, hs0, vs0, lt0, ft0, fc0};
  assign act[1] = {x1, y1, vo1, hs1, vs1, lt1, ft1, fc1};

  // timing table: hv hf hs hb vv vf vs vb
  int prm [2][8] = '{'{640, 16, 96, 48, 480, 10, 2, 33}, '{16, 4, 6, 5, 10, 2, 2, 3}};

  out_t q0[$], q1[$];
  out_t prev [2];
  int   tests = 0, fails = 0;
  int   n = 0;
  bit   free_run = 1'b1;
  int   hs_low = 0, hs_first = -1, lt_seen = 0;

  // Position n cycles after reset release, derived by plain division.
  function automatic out_t model(int k, int d);
    out_t m;
    int hv = prm[d][0], hf = prm[d][1], hs = prm[d][2], hb = prm[d][3];
    int vv = prm[d][4], vf = prm[d][5], vs = prm[d][6], vb = prm[d][7];
    int ht = hv + hf + hs + hb, vt = vv + vf + vs + vb;
    int x = k % ht, line = k / ht, y = line % vt, fr = line / vt;
    m.x           = 10'(x);
    m.y           = 10'(y);
    m.video_on    = (x < hv) && (y < vv);
    m.hsync       = !((x >= hv + hf) && (x < hv + hf + hs));
    m.vsync       = !((y >= vv + vf) && (y < vv + vf + vs));
    m.line_tick   = (x == ht - 1);
    m.frame_tick  = (x == 0) && (y == vv);
    m.frame_count = 16'(fr);
    return m;
  endfunction

  function automatic out_t reset_val();
    out_t r;
    r = '0;
    r.hsync = 1'b1;
    r.vsync = 1'b1;
    return r;
  endfunction

  task automatic push(int d, bit in_reset);
    out_t m, e;
    m = in_reset ? reset_val() : model(n, d);
    e = m;
`ifdef VGA_SYNC_DELAY_EN
    e.video_on = in_reset ? 1'b0 : prev[d].video_on;
    e.hsync    = in_reset ? 1'b1 : prev[d].hsync;
    e.vsync    = in_reset ? 1'b1 : prev[d].vsync;
`endif
    prev[d] = m;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Drive rst_n for the next edge and queue what that edge must produce.
  task automatic cycle(bit rst_low);
    @(negedge pclk);
    rst_n = !rst_low;
    push(0, rst_low);
    push(1, rst_low);
    if (rst_low) n = 0;
    else         n++;
  endtask

  task automatic check(string name, int got, int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  always begin
    out_t e;
    @(posedge pclk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      tests++;
      if (act[0] !== e) begin
        fails++;
        $display("FAIL full t=%0t: got %h required %h", $time, act[0], e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      tests++;
      if (act[1] !== e) begin
        fails++;
        $display("FAIL small t=%0t: got %h required %h", $time, act[1], e);
      end
    end
    if (free_run && rst_n && y0 == 10'd0 && fc0 == 16'd0) begin
      if (!hs0) begin
        if (hs_first < 0) hs_first = int'(x0);
        hs_low++;
      end
      if (lt0) lt_seen++;
    end
  end

  initial begin
    int len;
    for (int i = 0; i < 5; i++) cycle(1'b1);
    // Two full-size lines, about four small frames.
    for (int i = 0; i < 2000; i++) cycle(1'b0);
    @(posedge pclk);
    #2;
    check("hsync_low_cycles_line0", hs_low, 96);
`ifdef VGA_SYNC_DELAY_EN
    check("hsync_first_x", hs_first, 657);
`else
    check("hsync_first_x", hs_first, 656);
`endif
    check("line_tick_count_line0", lt_seen, 1);
    free_run = 1'b0;
    for (int r = 0; r < 20; r++) begin
      len = int'($urandom_range(50, 700));
      for (int i = 0; i < len; i++) cycle(1'b0);
      len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) cycle(1'b1);
    end
    for (int i = 0; i < 1200; i++) cycle(1'b0);
    @(posedge pclk);
    #2;
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
